// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// counter sizing and width-dependent operand constants.
package div_pkg;

  // state | meaning
  // IDLE  | waiting for start; results and flags held
  // PREP  | take operand magnitudes, record signs, detect zero divisor
  // CALC  | one restoring quotient bit per clock
  // FIX   | apply signs, register results, pulse done
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    FIX  = 2'd3
  } state_e;

  // Widest operand the constant helpers below can describe.
  localparam int MAX_WIDTH = 64;

  // Counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Most negative two's-complement value of the given width, zero-extended.
  function automatic logic [MAX_WIDTH-1:0] min_int(input int width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

  // All-ones value of the given width, zero-extended.
  function automatic logic [MAX_WIDTH-1:0] all_ones(input int width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < width; i++) v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the partial remainder left taking
// the next dividend bit, trial-subtract the divisor magnitude, keep the
// difference when it is non-negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   p_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH:0]   p_o,
  output logic             qbit_o
);

  // Two extra bits keep the trial difference's sign exact: the shifted
  // remainder is below 2*divisor, so the difference lies in (-2^W, 2^W).
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // Trial subtraction and restore select.
  always_comb begin
    shifted = {p_i, bit_i};
    diff    = shifted - {2'b00, dvsr_i};
    qbit_o  = ~diff[WIDTH+1];
    p_o     = qbit_o ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider, signed or unsigned, one quotient bit
// per clock with a start/busy/done handshake. Quotient truncates toward zero;
// remainder takes the dividend's sign. WIDTH must lie in 4..64.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow_flag
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MIN_INT  = WIDTH'(min_int(WIDTH));
  localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(all_ones(WIDTH));
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q;       // raw dividend, needed for the zero path
  logic [WIDTH-1:0] dvs_q;       // raw divisor
  logic             sgn_q;
  logic [WIDTH-1:0] a_q;         // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] b_q;         // divisor magnitude
  logic [WIDTH:0]   p_q;         // partial remainder
  logic             qneg_q;
  logic             rneg_q;
  logic             zero_q;
  logic             ovf_pend_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;
  logic             ovf_q;

  logic [WIDTH:0]   p_d;
  logic             qbit_d;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] rem_mag;

  // Magnitudes: MIN_INT negates to itself, which reads correctly as unsigned.
  assign dvd_mag = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
  assign dvs_mag = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
  assign rem_mag = p_q[WIDTH-1:0];

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .p_i   (p_q),
    .bit_i (a_q[WIDTH-1]),
    .dvsr_i(b_q),
    .p_o   (p_d),
    .qbit_o(qbit_d)
  );

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      sgn_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      p_q        <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      zero_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q   <= dividend;
            dvs_q   <= divisor;
            sgn_q   <= is_signed;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= PREP;
          end
        end
        PREP: begin
          a_q        <= dvd_mag;
          b_q        <= dvs_mag;
          p_q        <= '0;
          qneg_q     <= sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
          rneg_q     <= sgn_q & dvd_q[WIDTH-1];
          zero_q     <= (dvs_q == '0);
          ovf_pend_q <= sgn_q && (dvd_q == MIN_INT) && (dvs_q == ALL_ONES);
          if (dvs_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q   <= CNT_LOAD;
            state_q <= CALC;
          end
        end
        CALC: begin
          p_q   <= p_d;
          a_q   <= {a_q[WIDTH-2:0], qbit_d};
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_q <= FIX;
        end
        FIX: begin
          if (zero_q) begin
            quot_q <= ALL_ONES;
            rem_q  <= dvd_q;
            dbz_q  <= 1'b1;
          end else begin
            quot_q <= qneg_q ? -a_q : a_q;
            rem_q  <= rneg_q ? -rem_mag : rem_mag;
            ovf_q  <= ovf_pend_q;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign quotient      = quot_q;
  assign remainder     = rem_q;
  assign div_by_zero   = dbz_q;
  assign overflow_flag = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=32): hand-computed quotient and
// remainder, handshake timing, zero/overflow paths, reset mid-operation and
// back-to-back starts.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow_flag;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .is_signed    (is_signed),
    .dividend     (dividend),
    .divisor      (divisor),
    .busy         (busy),
    .done         (done),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero),
    .overflow_flag(overflow_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Launches one operation, follows it to done and
  // returns at the negedge where done is high (or after the cycle budget).
  // poke_at > 0 pulses a spurious start with different operands mid-run.
  task automatic run_op(input string tag, input logic sgn,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                        input logic exp_dbz, input logic exp_ovf,
                        input int exp_lat, input int poke_at);
    int   cycles;
    logic busy_ok;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    cycles  = 1;
    busy_ok = 1'b1;
    chk({tag, "_busy_first"}, 64'(busy), 64'd1);
    chk({tag, "_done_first"}, 64'(done), 64'd0);
    while (!done && cycles < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (poke_at != 0 && cycles == poke_at) begin
        start     = 1'b1;
        is_signed = ~sgn;
        dividend  = 32'd3;
        divisor   = 32'd3;
      end
      if (poke_at != 0 && cycles == poke_at + 1) start = 1'b0;
      @(negedge clk);
      cycles++;
    end
    chk({tag, "_latency"}, 64'(cycles), 64'(exp_lat));
    chk({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_q"}, 64'(quotient), 64'(exp_q));
    chk({tag, "_r"}, 64'(remainder), 64'(exp_r));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
    chk({tag, "_ovf"}, 64'(overflow_flag), 64'(exp_ovf));
  endtask

  // One idle cycle after done: pulse must have dropped, results held.
  task automatic after_done(input string tag, input logic [W-1:0] exp_q);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_q_held"}, 64'(quotient), 64'(exp_q));
  endtask

  initial begin
    int   seen_done;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_q", 64'(quotient), 64'd0);
    chk("rst_r", 64'(remainder), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    run_op("s100_7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 35, 0);
    after_done("s100_7", 32'd14);
    run_op("sn100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 35, 0);
    after_done("sn100_7", 32'hFFFF_FFF2);
    run_op("s100_n7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0, 35, 0);
    after_done("s100_n7", 32'hFFFF_FFF2);
    run_op("sn100_n7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0, 35, 0);
    after_done("sn100_n7", 32'd14);
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 35, 0);
    after_done("s_ovf", 32'h8000_0000);
    run_op("u_minint", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 35, 0);
    after_done("u_minint", 32'd0);
    run_op("div0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, 3, 0);
    after_done("div0", 32'hFFFF_FFFF);
    run_op("u_max_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 35, 10);
    after_done("u_max_2", 32'h7FFF_FFFF);

    // Reset ten cycles into an operation.
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_q", 64'(quotient), 64'd0);
    chk("mid_rst_r", 64'(remainder), 64'd0);
    chk("mid_rst_dbz", 64'(div_by_zero), 64'd0);
    chk("mid_rst_ovf", 64'(overflow_flag), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1;
    end
    chk("no_activity_after_rst", 64'(seen_done), 64'd0);

    run_op("u81_9", 1'b0, 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 35, 0);
    // Start coincident with done: accepted at the very next edge.
    run_op("b2b_sn7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 35, 0);
    after_done("b2b_sn7_2", 32'hFFFF_FFFD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential radix-2 restoring integer divider; the inverse counterpart to the combinational tree multiplier.
- Computes quotient and remainder of two WIDTH-bit operands, signed or unsigned, one quotient bit per clock.
- Uses a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic unit and shares its operand width and overflow-flag convention.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 4.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = two's-complement division, 0 = unsigned; captured with start.
- dividend  input  WIDTH  captured on accepted start.
- divisor  input  WIDTH  captured on accepted start.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle pulse when results are valid.
- quotient  output  WIDTH  held until the next accepted start.
- remainder  output  WIDTH  held until the next accepted start.
- div_by_zero  output  1  sticky with results.
- overflow_flag  output  1  signed MIN_INT / -1; sticky with results.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (any time, including mid-operation):
  - State goes to IDLE.
  - busy, done, quotient, remainder, div_by_zero and overflow_flag all go to 0.
  - Internal counter and registers are cleared.
  - No partial result is ever presented.
- States: IDLE, PREP, CALC, FIX.
- IDLE:
  - start=1 at edge N captures operands and is_signed, clears flags, and moves to PREP.
  - busy=1 from N+1.
- PREP (1 cycle):
  - Takes magnitudes: absolute value if is_signed and MSB=1, else raw.
  - Records quotient sign = dividend MSB XOR divisor MSB (signed only).
  - Records remainder sign = dividend MSB (signed only).
  - Divisor == 0: go to FIX with the zero path selected.
  - Otherwise: load count = WIDTH and go to CALC.
- CALC (WIDTH cycles):
  - Partial remainder P (WIDTH+1 bits) shifts left, taking the next dividend MSB.
  - T = P - |divisor|. If T >= 0, P = T and qbit = 1; else qbit = 0.
  - count decrements; on count reaching 1, go to FIX.
- FIX (1 cycle):
  - Applies signs and registers outputs; done=1, busy=0; next state IDLE.
  - Normal path: edge N+WIDTH+2 registers the results, so done is visible in the following cycle (cycle 35 after the start edge for WIDTH=32).
  - Zero path: edge N+2; quotient = all ones, remainder = dividend (unchanged), div_by_zero = 1.
- Arithmetic:
  - Truncating division: quotient rounds toward zero; remainder takes the dividend's sign.
  - Identity dividend = q*divisor + r holds except in the divide-by-zero case.
- Overflow:
  - Condition: is_signed, dividend = 100..0, divisor = all ones.
  - Result follows the normal path: quotient = 100..0 (the magnitude 2^(WIDTH-1) wraps), remainder = 0, overflow_flag = 1.
  - Unsigned operation never sets overflow_flag.
- Handshake rules:
  - start while busy is ignored; inputs may change freely while busy.
  - start in the same cycle done is high is accepted: state is IDLE at that edge, so back-to-back ops have no bubble beyond FIX.
- done is exactly one cycle. Results and flags hold until the edge that accepts the next start, where both flags clear.

Decomposition:
- Package div_pkg holds:
  - the state encoding (IDLE=0, PREP=1, CALC=2, FIX=3);
  - the counter width as $clog2(WIDTH+1);
  - MIN_INT / all-ones constant functions of WIDTH.
- One combinational sub-module, div_step:
  - Inputs: P, next dividend bit, |divisor|.
  - Outputs: new P and qbit.
- The top module holds the FSM, counter, sign/fix logic and output registers.

Test Plan:
- Signed 100 / 7, start pulse at N:
  - busy high N+1..N+34.
  - done high for exactly the cycle following edge N+34 (WIDTH=32).
  - quotient=14, remainder=2, both flags 0.
- Signed sign combinations:
  - -100/7 -> q=0xFFFFFFF2, r=0xFFFFFFFE.
  - 100/-7 -> q=0xFFFFFFF2, r=2.
  - -100/-7 -> q=14, r=0xFFFFFFFE.
- Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, overflow_flag=1, div_by_zero=0.
- Same operands unsigned -> q=0, r=0x80000000, overflow_flag=0.
- 5 / 0 with start at N:
  - done for the cycle following edge N+2.
  - q=0xFFFFFFFF, r=5, div_by_zero=1.
- Unsigned 0xFFFFFFFF / 2 -> q=0x7FFFFFFF, r=1. A second start pulsed mid-CALC is ignored, and results match the first operands.
- rst_n low for one cycle 10 cycles after start:
  - All outputs go to 0 immediately (asynchronous), and no done pulse follows.
  - A new 81/9 then yields q=9, r=0.
  - Back-to-back start coincident with done is accepted.
